// File: rtl/serial_adder_pkg.sv
// +-------------------------------------------------------------------------+
// | serial_adder_pkg : shared word width and FSM states for serial adder    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ser_hold_reg.sv
// +-------------------------------------------------------------------------+
// | ser_hold_reg : single-entry valid/ready holding register with overrun   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module ser_hold_reg #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (load) begin
      // A completion landing on an accepted word reloads without a bubble.
      if (!r_valid || ready) begin
        r_q     <= data;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign q       = r_q;
  assign valid   = r_valid;
  assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/serial_sum_collector.sv
// +-------------------------------------------------------------------------+
// | serial_sum_collector : LSB-first serial sum to parallel word + carry    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module serial_sum_collector
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             bit_first,
  input  logic             carry_in,
  output logic [WIDTH-1:0] word_out,
  output logic             carry_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int               c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic               r_busy;
  logic               r_frame_err;

  logic               w_start;
  logic               w_cont;
  logic               w_orphan;
  logic               w_complete;
  logic [WIDTH-1:0]   w_shift;
  logic [WIDTH:0]     w_hold_q;

  always_comb begin
    w_start  = bit_valid && bit_first;
    w_cont   = bit_valid && !bit_first && (r_state == COLLECT);
    w_orphan = bit_valid && !bit_first && (r_state == IDLE);

    w_shift = r_shift;
    if (w_start) begin
      w_shift = WIDTH'(bit_in);
    end else if (w_cont) begin
      w_shift = r_shift | (WIDTH'(bit_in) << r_cnt);
    end

    // The assembled word is taken combinationally so it lands one edge after the last bit.
    w_complete = (w_start && (WIDTH == 1)) || (w_cont && (r_cnt == c_last));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_shift     <= w_shift;
      r_frame_err <= w_orphan || (w_start && (r_state == COLLECT));
      r_busy      <= !w_complete && (w_start || (r_state == COLLECT));

      if (w_complete) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (w_start) begin
        r_state <= COLLECT;
        r_cnt   <= c_cnt_w'(1);
      end else if (w_cont) begin
        r_cnt   <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  ser_hold_reg #(
    .WIDTH (WIDTH + 1)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (w_complete),
    .data    ({carry_in, w_shift}),
    .ready   (word_ready),
    .q       (w_hold_q),
    .valid   (word_valid),
    .overrun (overrun)
  );

  assign word_out  = w_hold_q[WIDTH-1:0];
  assign carry_out = w_hold_q[WIDTH];
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_sum_collector.sv
// +-------------------------------------------------------------------------+
// | tb_serial_sum_collector : directed + random bench against a frame model |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_serial_sum_collector;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         bit_valid;
  logic         bit_in;
  logic         bit_first;
  logic         carry_in;
  logic         word_ready;
  logic [W-1:0] word_out;
  logic         carry_out;
  logic         word_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the open frame kept in a queue, output port as plain variables.
  bit           frame_q[$];
  bit           in_frame;
  logic [W-1:0] m_word;
  bit           m_carry;
  bit           m_valid;
  bit           m_ovr;
  bit           m_err;

  serial_sum_collector #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_first  (bit_first),
    .carry_in   (carry_in),
    .word_out   (word_out),
    .carry_out  (carry_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit b, input bit f, input bit c, input bit rdy);
    bit           done;
    logic [W-1:0] word;
    done  = 1'b0;
    word  = '0;
    m_err = 1'b0;
    if (r) begin
      frame_q.delete();
      in_frame = 1'b0;
      m_word   = '0;
      m_carry  = 1'b0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      return;
    end
    if (v) begin
      if (f) begin
        if (in_frame) m_err = 1'b1;
        frame_q.delete();
        frame_q.push_back(b);
        in_frame = 1'b1;
      end else if (in_frame) begin
        frame_q.push_back(b);
      end else begin
        m_err = 1'b1;
      end
    end
    if (in_frame && frame_q.size() == W) begin
      done = 1'b1;
      for (int i = 0; i < W; i++) word = word + (W'(frame_q[i]) << i);
      frame_q.delete();
      in_frame = 1'b0;
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_word  = word;
        m_carry = c;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit b, input bit f, input bit c, input bit rdy);
    @(negedge clk);
    rst        = r;
    bit_valid  = v;
    bit_in     = b;
    bit_first  = f;
    carry_in   = c;
    word_ready = rdy;
    @(posedge clk);
    model(r, v, b, f, c, rdy);
    #1;
    check("word_valid", word_valid, m_valid);
    check("word_out", word_out, m_word);
    check("carry_out", carry_out, m_carry);
    check("busy", busy, in_frame);
    check("frame_err", frame_err, m_err);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rdy);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit c, input int gap, input bit rdy);
    logic [W-1:0] wv;
    wv = w;
    for (int i = 0; i < W; i++) begin
      idle(gap, rdy);
      // Carry on non-last bits is noise the DUT must ignore.
      step(0, 1, wv[i], i == 0, (i == W - 1) ? c : 1'($urandom), rdy);
    end
  endtask

  initial begin
    rst = 1'b1; bit_valid = 0; bit_in = 0; bit_first = 0; carry_in = 0; word_ready = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1);

    send_frame(4'b1101, 1, 0, 1);
    idle(2, 1);

    send_frame(4'h3, 0, 0, 0);
    send_frame(4'hA, 1, 0, 0);
    idle(2, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(3, 0);
    step(1, 0, 0, 0, 0, 0);

    send_frame(4'h6, 0, 2, 1);
    idle(1, 1);

    step(0, 1, 1, 1, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    send_frame(4'h9, 1, 0, 1);
    idle(2, 1);

    step(0, 1, 1, 0, 0, 1);
    idle(1, 1);
    step(0, 1, 1, 1, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 1, 1);
    send_frame(4'hF, 1, 0, 1);
    idle(1, 1);

    send_frame(4'h1, 0, 0, 1);
    send_frame(4'h2, 1, 0, 1);
    idle(2, 1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        send_frame(W'($urandom), 1'($urandom), $urandom_range(0, 1), $urandom_range(0, 2) != 0);
      end else begin
        for (int k = 0; k < 8; k++) begin
          step($urandom_range(0, 60) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
               $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 9) < 6);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_sum_collector.md
# serial_sum_collector

Deserializing end of the serial adder datapath. Samples the LSB-first serial sum stream plus final carry from the bit-serial adder stage, assembles each frame into a parallel WIDTH-bit word, and presents it on a valid/ready output port with a single-entry holding register. Sits between the serial full-adder slice and any parallel consumer.

## Interface
- WIDTH, 4, bits per frame (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- bit_valid  in  1  bit_in / bit_first / carry_in valid this cycle
- bit_in  in  1  serial sum bit, LSB first
- bit_first  in  1  marks bit 0 of a frame (qualified by bit_valid)
- carry_in  in  1  adder carry; sampled only with a frame's last bit
- word_out  out  WIDTH  assembled sum word
- carry_out  out  1  carry captured with the last bit
- word_valid  out  1  word_out/carry_out hold a frame
- word_ready  in  1  consumer accepts when word_valid && word_ready
- busy  out  1  frame in progress (COLLECT state)
- frame_err  out  1  one-cycle pulse on framing violation
- overrun  out  1  sticky; a completed frame was dropped

## Operation
- Reset: all outputs 0; state IDLE; bit count 0; shift register 0.
- States: IDLE, COLLECT. Bit count cnt, width $clog2(WIDTH+1).
- IDLE: bit_valid && bit_first -> bit_in to shift position 0, cnt=1, go COLLECT (WIDTH==1: frame completes immediately, stay IDLE). bit_valid && !bit_first -> bit dropped, frame_err pulse.
- COLLECT: bit_valid && !bit_first -> bit_in to position cnt, cnt+1. On the WIDTH-th bit: frame complete, carry_in captured, go IDLE, cnt=0.
- COLLECT + bit_valid && bit_first: partial frame discarded, frame_err pulse, new frame starts with this bit as bit 0 (cnt=1).
- bit_valid low: state and cnt hold; no timeout.
- Output register: on frame completion, load word/carry and set word_valid if word_valid was 0 or word_ready is 1 that cycle. If word_valid && !word_ready at completion: new frame dropped, held word unchanged, overrun set.
- word_valid && word_ready with no completion: word_valid clears; word_out/carry_out keep last value.
- overrun clears only on rst.
- busy = (state == COLLECT).

## Timing
- Last bit sampled at edge k -> word_valid, word_out, carry_out updated after edge k (visible cycle k+1).
- Back-to-back frames: bit_first may arrive the cycle after a last bit; sustained rate one word per WIDTH cycles with word_ready tied high.
- Handshake transfer at edge where word_valid && word_ready; simultaneous completion reloads without a bubble (word_valid stays 1).
- frame_err high for exactly the cycle after the offending edge.
- rst mid-frame: partial frame, held word and overrun all cleared at that edge; bits presented in the rst cycle ignored.

## Structure
- Package serial_adder_pkg: WIDTH default, state enum (IDLE, COLLECT), shared with the serializer side.
- One sub-module: ser_hold_reg — WIDTH+1-bit valid/ready holding register (load, accept, overrun detect).
- Top holds FSM, counter, shift register.

## Test plan
- WIDTH=4, bits 1,0,1,1 (first on bit 0), carry_in=1 on last -> word_out=4'b1101, carry_out=1, word_valid one cycle after last bit.
- word_ready=0, send frame 4'h3 then frame 4'hA -> word_out stays 4'h3, overrun=1; ready pulse clears word_valid; overrun stays 1 until rst.
- Frame with bit_valid gaps (valid every 3rd cycle) for 4'h6 -> word_out=4'h6, busy high throughout.
- bit_first after 2 bits, then full frame 4'h9 -> frame_err single pulse, word_out=4'h9, only one word_valid.
- Orphan bit (valid, !first) in IDLE -> frame_err pulse, no state change; rst asserted mid-frame -> all outputs 0, next clean frame 4'hF assembles correctly.
- word_ready=1 continuously, back-to-back frames 4'h1,4'h2 -> word_valid pulses, no overrun, words in order.
